// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked ALU.
// Single-cycle ops complete in one cycle. MUL/DIVU/REMU are iterative
// (WIDTH cycles) and exist only when SEQ_ALU_MULDIV_EN is defined;
// without it those opcodes complete as illegal single-cycle ops.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_DONE = 1'b1} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_ill;
  logic             w_load;
  logic [WIDTH-1:0] w_ld_res;
  logic             w_ld_carry;
  logic             w_ld_ovf;
  logic             w_ld_ill;

  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign w_shamt   = operand_b[SHW-1:0];

  // Single-cycle result and flags straight from the request operands
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (alu_control)
      OP_ADD: begin
        w_sum   = {1'b0, operand_a} + {1'b0, operand_b};
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (operand_a[MSB] == operand_b[MSB]) && (w_res[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        w_sum   = {1'b0, operand_a} - {1'b0, operand_b};
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (operand_a[MSB] != operand_b[MSB]) && (w_res[MSB] != operand_a[MSB]);
      end
      OP_AND:  w_res = operand_a & operand_b;
      OP_OR:   w_res = operand_a | operand_b;
      OP_XOR:  w_res = operand_a ^ operand_b;
      OP_SLL:  w_res = operand_a << w_shamt;
      OP_SRL:  w_res = operand_a >> w_shamt;
      OP_SRA:  w_res = $signed(operand_a) >>> w_shamt;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      default: w_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             w_is_md;
  logic             w_last;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_is_md = (alu_control == OP_MUL) || (alu_control == OP_DIVU) ||
                   (alu_control == OP_REMU);
  assign w_last  = (r_cnt == SHW'(WIDTH - 1));

  // One multiply (shift-add) or restoring-divide step on {r_hi, r_lo}
  always_comb begin
    w_acc    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {WIDTH{1'b0}})};
    w_rem_sh = {r_hi, r_lo[MSB]};
    // Low WIDTH bits of the difference are all that survive a restore.
    w_diff   = w_rem_sh[MSB:0] - r_b;
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    if (r_op == OP_MUL) begin
      w_hi_next = w_acc[WIDTH:1];
      w_lo_next = {w_acc[0], r_lo[MSB:1]};
    end else begin
      w_hi_next = w_ge ? w_diff : w_rem_sh[MSB:0];
      w_lo_next = {r_lo[MSB-1:0], w_ge};
    end
  end

  // Iteration registers: r_hi = product high / remainder, r_lo = multiplier / quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (w_accept && w_is_md) begin
      r_cnt <= '0;
      r_op  <= alu_control;
      r_hi  <= '0;
      r_lo  <= operand_a;
      r_b   <= operand_b;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt + SHW'(1);
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
    end
  end
`endif

  // Select what (if anything) is written into the output registers this cycle
  always_comb begin
    w_load     = 1'b0;
    w_ld_res   = w_res;
    w_ld_carry = w_carry;
    w_ld_ovf   = w_ovf;
    w_ld_ill   = w_ill;
`ifdef SEQ_ALU_MULDIV_EN
    if ((r_state == ST_BUSY) && w_last) begin
      w_load   = 1'b1;
      w_ld_ovf = 1'b0;
      w_ld_ill = 1'b0;
      if (r_op == OP_MUL) begin
        w_ld_res   = w_lo_next;
        w_ld_carry = |w_hi_next;
      end else begin
        // A zero divisor naturally yields all-ones quotient and remainder = a.
        w_ld_res   = (r_op == OP_DIVU) ? w_lo_next : w_hi_next;
        w_ld_carry = (r_b == '0);
      end
    end else if (w_accept && !w_is_md) begin
      w_load = 1'b1;
    end
`else
    w_load = w_accept;
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (w_accept) w_state_next = w_is_md ? ST_BUSY : ST_DONE;
`else
        if (w_accept) w_state_next = ST_DONE;
`endif
      end
`ifdef SEQ_ALU_MULDIV_EN
      ST_BUSY: if (w_last) w_state_next = ST_DONE;
`endif
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Registered result and flags; zero is taken from the value being stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
    end else if (w_load) begin
      result        <= w_ld_res;
      zero_flag     <= (w_ld_res == '0);
      carry_flag    <= w_ld_carry;
      overflow_flag <= w_ld_ovf;
      illegal_op    <= w_ld_ill;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH=16) against an
// arithmetic reference model. Honours SEQ_ALU_MULDIV_EN like the design.
module tb_seq_alu;
  localparam int W = 16;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero_flag;
  logic         carry_flag;
  logic         overflow_flag;
  logic         illegal_op;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] op);
    return MD && (op == 4'hA || op == 4'hC || op == 4'hD);
  endfunction

  // Reference model: plain arithmetic on the operand values.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output logic il);
    logic [31:0] wide;
    r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (op)
      4'h0: begin
        wide = 32'(a) + 32'(b);
        r = wide[W-1:0];
        c = (wide > 32'hFFFF);
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h1: begin
        r = a - b;
        c = (a < b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << b[3:0];
      4'h6: r = a >> b[3:0];
      4'h7: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'h8: r = W'($signed(a) >>> b[3:0]);
      4'h9: r = (a < b) ? 16'd1 : 16'd0;
      4'hA: if (MD) begin
              wide = 32'(a) * 32'(b);
              r = wide[W-1:0];
              c = (wide[31:16] != 16'd0);
            end else il = 1'b1;
      4'hC: if (MD) begin
              if (b == 0) begin r = 16'hFFFF; c = 1'b1; end
              else r = a / b;
            end else il = 1'b1;
      4'hD: if (MD) begin
              if (b == 0) begin r = a; c = 1'b1; end
              else r = a % b;
            end else il = 1'b1;
      default: il = 1'b1;
    endcase
  endtask

  // One full transaction: request, wait for result, check, optionally stall, drain.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic ec, ev, eil;
    int lat, exp_lat;
    bit saw_ready;
    model(op, a, b, er, ec, ev, eil);
    exp_lat = is_iter(op) ? W + 1 : 1;
    @(negedge clk);
    check($sformatf("op%0h_in_ready_idle", op), 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_control = op; operand_a = a; operand_b = b;
    @(posedge clk);
    lat = 1;
    saw_ready = 1'b0;
    @(negedge clk);
    // Scramble the inputs: they must be ignored outside IDLE.
    in_valid = 1'($urandom_range(0, 1));
    alu_control = 4'($urandom);
    operand_a = W'($urandom);
    operand_b = W'($urandom);
    while (1) begin
      if (in_ready) saw_ready = 1'b1;
      if (out_valid || lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    check($sformatf("op%0h_latency", op), 32'(lat), 32'(exp_lat));
    check($sformatf("op%0h_in_ready_busy", op), 32'(saw_ready), 32'd0);
    check($sformatf("op%0h_result", op), 32'(result), 32'(er));
    check($sformatf("op%0h_zero", op), 32'(zero_flag), 32'(er == 0));
    check($sformatf("op%0h_carry", op), 32'(carry_flag), 32'(ec));
    check($sformatf("op%0h_ovf", op), 32'(overflow_flag), 32'(ev));
    check($sformatf("op%0h_illegal", op), 32'(illegal_op), 32'(eil));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("op%0h_hold_state", op), {30'd0, out_valid, in_ready}, 32'b10);
      check($sformatf("op%0h_hold_data", op),
            {13'd0, result, zero_flag, carry_flag, overflow_flag},
            {13'd0, er, (er == 0), ec, ev});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check($sformatf("op%0h_drain", op), {30'd0, out_valid, in_ready}, 32'b01);
    $display("op=%h a=%h b=%h -> result=%h z=%0d c=%0d v=%0d ill=%0d lat=%0d",
             op, a, b, result, zero_flag, carry_flag, overflow_flag, illegal_op, lat);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  logic [3:0]   d_op [13] = '{4'h0, 4'h1, 4'h8, 4'hA, 4'hC, 4'hD, 4'hC, 4'hD,
                              4'h2, 4'hE, 4'h7, 4'h9, 4'h0};
  logic [W-1:0] d_a  [13] = '{16'h7FFF, 16'h0003, 16'h8000, 16'h0300, 16'd100, 16'd100,
                              16'h1234, 16'h1234, 16'hF0F0, 16'h5555, 16'h8000, 16'h8000,
                              16'hFFFF};
  logic [W-1:0] d_b  [13] = '{16'h0001, 16'h0005, 16'h0004, 16'h0100, 16'd7, 16'd7,
                              16'h0000, 16'h0000, 16'hFF00, 16'h1111, 16'h0001, 16'h0001,
                              16'h0001};
  int           d_hold [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", {out_valid, in_ready, result, zero_flag, carry_flag,
                          overflow_flag, illegal_op}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_op(d_op[i], d_a[i], d_b[i], d_hold[i]);

    // Reset asserted while an op is in flight (mid-MUL when enabled)
    @(negedge clk);
    in_valid = 1'b1;
    alu_control = MD ? 4'hA : 4'h0;
    operand_a = 16'h1234;
    operand_b = 16'h0101;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {out_valid, in_ready, result, zero_flag, carry_flag,
                             overflow_flag, illegal_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h0, 16'd2, 16'd2, 0);
    run_op(4'hE, 16'h1234, 16'h4321, 0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick_val(), pick_val(),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the processor's combinational ALU. It is WIDTH-generic and registers its result and flags. It adds SRA, SLTU and iterative multiply/divide operations, which take WIDTH cycles each. It sits between decode/operand-fetch and writeback, and uses valid/ready handshakes on both sides so the pipeline can stall on multi-cycle ops.

Parameters:
WIDTH, 16, operand/result width; must be a power of two, minimum 8.
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
alu_control  input  4  opcode
operand_a  input  WIDTH  first operand
operand_b  input  WIDTH  second operand / shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero_flag  output  1  registered: result == 0
carry_flag  output  1  registered carry/borrow/mul-overflow/div-by-zero
overflow_flag  output  1  registered signed overflow
illegal_op  output  1  registered: opcode unsupported

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0. result, zero_flag, carry_flag, overflow_flag, illegal_op and out_valid are all 0. in_ready is 0 while rst_n is low. Any op in progress is discarded.
- in_ready = (state == IDLE) && rst_n. A request is accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE: on accept of a single-cycle op, register result/flags and go to DONE. On accept of MUL/DIVU/REMU, latch operands, clear the counter and go to BUSY.
  - BUSY: one iteration per cycle. After WIDTH iterations (counter == WIDTH-1), register result/flags and go to DONE.
  - DONE: out_valid = 1. result and flags hold stable until out_ready is 1; then go to IDLE.
- No new request is accepted in DONE, even when out_ready is high in the same cycle. Back-to-back throughput for single-cycle ops is one op per 2 cycles.
- Latency from the accept edge to out_valid high: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL/DIVU/REMU.
- Inputs are ignored outside IDLE. Operands need not be held after accept.
- Opcodes, with flags 0 unless stated:
  - 0000 ADD: carry = carry-out. overflow = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]).
  - 0001 SUB: carry = borrow (a < b unsigned). overflow = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise.
  - 0101 SLL, 0110 SRL, 1000 SRA: shift amount is b[SHW-1:0]. SRA is sign-filling.
  - 0111 SLT: signed compare, result 1 or 0.
  - 1001 SLTU: unsigned compare, result 1 or 0.
  - 1010 MUL: shift-add. result = low WIDTH bits of the unsigned product. carry = (high half != 0).
  - 1100 DIVU: restoring division, result = quotient.
  - 1101 REMU: restoring division, result = remainder.
  - Divide by zero: DIVU returns all-ones, REMU returns a, carry = 1. Full WIDTH-cycle latency is kept.
  - 1011, 1110, 1111: completed as single-cycle ops with result 0, illegal_op = 1, and all other flags 0 except zero_flag = 1.
- zero_flag is derived from the value being registered into result, so it is always consistent with result.
- Arithmetic is modulo 2^WIDTH. Intermediate sums use WIDTH+1 bits; the multiply accumulator uses 2*WIDTH bits.

Optional Feature:
SEQ_ALU_MULDIV_EN.
- Defined: MUL/DIVU/REMU, the BUSY state and the iteration counter are implemented as above.
- Undefined: 1010, 1100 and 1101 are treated as illegal (single-cycle, result 0, illegal_op = 1). No BUSY state or counter logic is synthesised.

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001 -> out_valid 1 cycle after accept; result 0x8000, overflow=1, carry=0, zero=0.
- SUB a=0x0003 b=0x0005 -> result 0xFFFE, carry=1, overflow=0. SRA a=0x8000 b=0x0004 -> 0xF800.
- MUL (macro on) a=0x0300 b=0x0100 -> out_valid exactly 17 cycles after accept; result 0x0000, carry=1, zero=1. in_ready stays 0 throughout.
- DIVU a=100 b=7 -> 14; REMU a=100 b=7 -> 2. DIVU a=0x1234 b=0 -> 0xFFFF, carry=1; REMU a=0x1234 b=0 -> 0x1234, carry=1.
- Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 mid-MUL -> all outputs 0 immediately. After release, in_ready=1, and ADD 2+2 then returns 4. Opcode 1110 -> result 0, illegal_op=1, zero=1.
